mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-ported, synchronous-read 4K×32 SRAM between the instruction-fetch port and the load/store port. It replaces the multi-ported behavioural memory array. Fetches at a halfword offset are split into two SRAM reads, and sub-word stores become byte-masked writes. It sits between IF/MEM pipeline stages and the SRAM macro.

---
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported sync-read SRAM between instruction fetch and load/store.
// Latency: store resp T+2, load/aligned fetch T+3, split (halfword-offset) fetch T+4 after accept edge T.
// Backpressure: requests held by ready (one grant per arbitration cycle); responses are unconditional pulses.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req_*  / if_resp_*           instruction fetch request (addr) and response (instr)
//   dm_req_*  / dm_resp_*           load/store request (we, width, sign, addr, wdata) and response (rdata)
//   sram_*                          SRAM macro command (en, we, wmask, addr, wdata) and read data
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int SRAM_AW      = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [31:0]           if_resp_instr,
    input  logic                  dm_req_valid,
    input  logic                  dm_req_we,
    input  logic [1:0]            dm_req_width,
    input  logic                  dm_req_sign,
    input  logic [ADDR_WIDTH-1:0] dm_req_addr,
    input  logic [31:0]           dm_req_wdata,
    output logic                  dm_req_ready,
    output logic                  dm_resp_valid,
    output logic [31:0]           dm_resp_rdata,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [3:0]            sram_wmask,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    localparam int                SW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     LIM = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPT, RESP} state_t;

    state_t               r_state;
    logic [SW-1:0]        r_starve;
    logic                 r_is_if;
    logic                 r_we;
    logic [1:0]           r_width;
    logic                 r_sign;
    logic [SRAM_AW+1:0]   r_addr;
    logic [31:0]          r_word0;
    logic                 r_if_resp_vld;
    logic [31:0]          r_if_resp_instr;
    logic                 r_dm_resp_vld;
    logic [31:0]          r_dm_resp_rdata;
    logic                 r_sram_en;
    logic                 r_sram_we;
    logic [3:0]           r_sram_wmask;
    logic [SRAM_AW-1:0]   r_sram_addr;
    logic [31:0]          r_sram_wdata;

    logic                 w_arb;
    logic                 w_force_if;
    logic                 w_unused;

    // Address bits above the SRAM window are deliberately ignored.
    assign w_unused = ^{if_req_addr[ADDR_WIDTH-1:SRAM_AW+2], dm_req_addr[ADDR_WIDTH-1:SRAM_AW+2]};

    // Arbitration happens in IDLE and RESP; data wins unless fetch has starved long enough.
    assign w_arb        = (r_state == IDLE) || (r_state == RESP);
    assign w_force_if   = (r_starve >= LIM);
    assign dm_req_ready = w_arb & dm_req_valid & ~(if_req_valid & w_force_if);
    assign if_req_ready = w_arb & if_req_valid & ~dm_req_ready;

    assign if_resp_valid = r_if_resp_vld;
    assign if_resp_instr = r_if_resp_instr;
    assign dm_resp_valid = r_dm_resp_vld;
    assign dm_resp_rdata = r_dm_resp_rdata;
    assign sram_en       = r_sram_en;
    assign sram_we       = r_sram_we;
    assign sram_wmask    = r_sram_wmask;
    assign sram_addr     = r_sram_addr;
    assign sram_wdata    = r_sram_wdata;

    function automatic logic [3:0] f_wmask(input logic [1:0] width, input logic [1:0] off);
        case (width)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Sub-word store data is replicated so the byte mask alone selects the lane.
    function automatic logic [31:0] f_wdata(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] width, input logic sign,
                                           input logic [1:0] off, input logic [31:0] w);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        h  = off[1] ? w[31:16] : w[15:0];
        case (width)
            2'b00:   return {{24{sign & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{sign & h[15]}}, h};
            2'b10:   return w;
            default: return 32'h0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_starve        <= '0;
            r_is_if         <= 1'b0;
            r_we            <= 1'b0;
            r_width         <= 2'b00;
            r_sign          <= 1'b0;
            r_addr          <= '0;
            r_word0         <= 32'h0;
            r_if_resp_vld   <= 1'b0;
            r_if_resp_instr <= 32'h0;
            r_dm_resp_vld   <= 1'b0;
            r_dm_resp_rdata <= 32'h0;
            r_sram_en       <= 1'b0;
            r_sram_we       <= 1'b0;
            r_sram_wmask    <= 4'b0000;
            r_sram_addr     <= '0;
            r_sram_wdata    <= 32'h0;
        end else begin
            r_if_resp_vld <= 1'b0;
            r_dm_resp_vld <= 1'b0;
            r_sram_en     <= 1'b0;
            r_sram_we     <= 1'b0;

            if (!if_req_valid || if_req_ready)
                r_starve <= '0;
            else if (dm_req_ready)
                r_starve <= r_starve + SW'(1);

            case (r_state)
                IDLE, RESP: begin
                    if (dm_req_ready) begin
                        r_state      <= ISSUE0;
                        r_is_if      <= 1'b0;
                        r_we         <= dm_req_we;
                        r_width      <= dm_req_width;
                        r_sign       <= dm_req_sign;
                        r_addr       <= dm_req_addr[SRAM_AW+1:0];
                        // Invalid width never touches the SRAM but still completes.
                        r_sram_en    <= (dm_req_width != 2'b11);
                        r_sram_we    <= dm_req_we & (dm_req_width != 2'b11);
                        r_sram_addr  <= dm_req_addr[SRAM_AW+1:2];
                        r_sram_wmask <= dm_req_we ? f_wmask(dm_req_width, dm_req_addr[1:0]) : 4'b0000;
                        if (dm_req_we)
                            r_sram_wdata <= f_wdata(dm_req_width, dm_req_wdata);
                    end else if (if_req_ready) begin
                        r_state      <= ISSUE0;
                        r_is_if      <= 1'b1;
                        r_we         <= 1'b0;
                        r_width      <= 2'b10;
                        r_sign       <= 1'b0;
                        r_addr       <= if_req_addr[SRAM_AW+1:0];
                        r_sram_en    <= 1'b1;
                        r_sram_addr  <= if_req_addr[SRAM_AW+1:2];
                        r_sram_wmask <= 4'b0000;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE0: begin
                    if (!r_is_if && r_we) begin
                        r_state         <= RESP;
                        r_dm_resp_vld   <= 1'b1;
                        r_dm_resp_rdata <= 32'h0;
                    end else if (r_is_if && r_addr[1]) begin
                        // Second half of a straddling instruction lives in the next word (wraps).
                        r_state     <= ISSUE1;
                        r_sram_en   <= 1'b1;
                        r_sram_addr <= r_addr[SRAM_AW+1:2] + SRAM_AW'(1);
                    end else begin
                        r_state <= CAPT;
                    end
                end
                ISSUE1: begin
                    r_word0 <= sram_rdata;
                    r_state <= CAPT;
                end
                CAPT: begin
                    r_state <= RESP;
                    if (r_is_if) begin
                        r_if_resp_vld   <= 1'b1;
                        r_if_resp_instr <= r_addr[1] ? {sram_rdata[15:0], r_word0[31:16]} : sram_rdata;
                    end else begin
                        r_dm_resp_vld   <= 1'b1;
                        r_dm_resp_rdata <= f_load(r_width, r_sign, r_addr[1:0], sram_rdata);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_instr;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [1:0]  dm_req_width;
    logic        dm_req_sign;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_resp_valid;
    logic [31:0] dm_resp_rdata;
    logic        sram_en;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .SRAM_AW(12), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_instr(if_resp_instr),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_width(dm_req_width),
        .dm_req_sign(dm_req_sign), .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
        .dm_req_ready(dm_req_ready), .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural single-ported synchronous-read SRAM.
    logic [31:0] mem [0:4095];
    int          en_cnt = 0;
    always @(posedge clk) begin
        if (sram_en) begin
            en_cnt <= en_cnt + 1;
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  width;
        bit          sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t dm_q[$];
    exp_t if_q[$];
    int   checks = 0;
    int   errors = 0;
    int   if_resp_cnt = 0;

    function automatic vec_t mk(input bit is_if, input bit we, input logic [1:0] width, input bit sign,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.is_if = is_if; v.we = we; v.width = width; v.sign = sign;
        v.addr = addr; v.wdata = wdata; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_if, input logic [31:0] data, input int lat);
        exp_t e;
        e.data = data;
        e.cyc  = cyc + lat;
        if (is_if) if_q.push_back(e);
        else       dm_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with valid dropped.
    task automatic issue(input vec_t v);
        bit got = 1'b0;
        int n   = 0;
        if (v.is_if) begin
            if_req_valid = 1'b1; if_req_addr = v.addr;
        end else begin
            dm_req_valid = 1'b1; dm_req_we = v.we; dm_req_width = v.width;
            dm_req_sign = v.sign; dm_req_addr = v.addr; dm_req_wdata = v.wdata;
        end
        while (!got && n < 50) begin
            #1;
            if ((v.is_if && if_req_ready) || (!v.is_if && dm_req_ready)) begin
                got = 1'b1;
                push_exp(v.is_if, v.exp, v.lat);
            end
            @(negedge clk);
            n++;
        end
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h actual=no_ready required=ready", v.addr);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((dm_q.size() != 0 || if_q.size() != 0) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (dm_q.size() != 0 || if_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", dm_q.size() + if_q.size());
            dm_q.delete();
            if_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[$];
        int   cnt0;
        int   en0;
        int   grants;
        int   budget;
        bit   got;
        logic [9:0] fetch_pat;

        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 32'h0;
        dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_width = 2'b00;
        dm_req_sign = 1'b0; dm_req_addr = 32'h0; dm_req_wdata = 32'h0;

        // Response scoreboard monitor: checks data and exact response cycle.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (dm_resp_valid === 1'b1) begin
                        checks++;
                        if (dm_q.size() == 0) begin
                            errors++;
                            $display("FAIL dm_resp_unexpected actual=%h@%0d required=none", dm_resp_rdata, cyc);
                        end else begin
                            e = dm_q.pop_front();
                            if (dm_resp_rdata !== e.data || cyc != e.cyc) begin
                                errors++;
                                $display("FAIL dm_resp actual=%h@%0d required=%h@%0d", dm_resp_rdata, cyc, e.data, e.cyc);
                            end
                        end
                    end
                    if (if_resp_valid === 1'b1) begin
                        if_resp_cnt++;
                        checks++;
                        if (if_q.size() == 0) begin
                            errors++;
                            $display("FAIL if_resp_unexpected actual=%h@%0d required=none", if_resp_instr, cyc);
                        end else begin
                            e = if_q.pop_front();
                            if (if_resp_instr !== e.data || cyc != e.cyc) begin
                                errors++;
                                $display("FAIL if_resp actual=%h@%0d required=%h@%0d", if_resp_instr, cyc, e.data, e.cyc);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_dm_resp_valid", 32'(dm_resp_valid), 32'h0);
        check("rst_if_resp_valid", 32'(if_resp_valid), 32'h0);
        check("rst_dm_resp_rdata", dm_resp_rdata, 32'h0);
        check("rst_if_resp_instr", if_resp_instr, 32'h0);
        check("rst_sram_en", 32'(sram_en), 32'h0);
        check("rst_sram_we", 32'(sram_we), 32'h0);
        check("rst_sram_wmask", 32'(sram_wmask), 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        check("rst_sram_wdata", sram_wdata, 32'h0);
        dm_req_valid = 1'b1;
        #1;
        check("rst_readys_idle", {30'h0, dm_req_ready, if_req_ready}, 32'h2);
        dm_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Pipelined request table: each accept may land in the previous RESP cycle.
        vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 2));
        vecs.push_back(mk(0, 0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3));
        vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0101, 32'h1234_5680, 32'h0000_0000, 2));
        vecs.push_back(mk(0, 0, 2'b00, 1, 32'h0000_0101, 32'h0,         32'hFFFF_FF80, 3));
        vecs.push_back(mk(0, 0, 2'b00, 0, 32'h0000_0101, 32'h0,         32'h0000_0080, 3));
        vecs.push_back(mk(0, 0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'hDEAD_80EF, 3));
        vecs.push_back(mk(0, 1, 2'b01, 0, 32'h0000_0102, 32'hA5A5_1234, 32'h0000_0000, 2));
        vecs.push_back(mk(0, 0, 2'b01, 1, 32'h0000_0102, 32'h0,         32'h0000_1234, 3));
        vecs.push_back(mk(0, 0, 2'b01, 1, 32'h0000_0100, 32'h0,         32'hFFFF_80EF, 3));
        vecs.push_back(mk(0, 0, 2'b01, 0, 32'h0000_0101, 32'h0,         32'h0000_80EF, 3));
        vecs.push_back(mk(0, 0, 2'b00, 1, 32'h0000_0103, 32'h0,         32'h0000_0012, 3));
        vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_0000, 32'h1111_2222, 32'h0000_0000, 2));
        vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_0004, 32'h3333_4444, 32'h0000_0000, 2));
        vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_0002, 32'h0,         32'h4444_1111, 4));
        vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_0000, 32'h0,         32'h1111_2222, 3));
        vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_0004, 32'h0,         32'h3333_4444, 3));
        vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_3FFC, 32'h5555_6666, 32'h0000_0000, 2));
        vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_3FFE, 32'h0,         32'h2222_5555, 4));
        vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1000_0100, 32'h0,         32'h1234_80EF, 3));
        for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);
        drain();

        // Both requesters held: four data grants, then a forced fetch grant, repeating.
        fetch_pat = 10'h210;
        grants = 0;
        budget = 0;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_width = 2'b10; dm_req_sign = 1'b0; dm_req_addr = 32'h0;
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        while (grants < 10 && budget < 100) begin
            #1;
            if (dm_req_ready || if_req_ready) begin
                check("arb_grant", {30'h0, dm_req_ready, if_req_ready},
                      fetch_pat[grants] ? 32'h1 : 32'h2);
                push_exp(if_req_ready && !dm_req_ready, 32'h1111_2222, 3);
                grants++;
            end
            @(negedge clk);
            budget++;
        end
        dm_req_valid = 1'b0;
        if_req_valid = 1'b0;
        check("arb_grant_count", 32'(grants), 32'd10);
        drain();

        // Reset during ISSUE1 of a split fetch drops the transaction.
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0002;
        got = 1'b0;
        budget = 0;
        while (!got && budget < 20) begin
            #1;
            got = if_req_ready;
            @(negedge clk);
            budget++;
        end
        if_req_valid = 1'b0;
        check("split_accept", 32'(got), 32'h1);
        @(negedge clk);
        check("issue1_sram_en", 32'(sram_en), 32'h1);
        check("issue1_sram_addr", 32'(sram_addr), 32'h1);
        cnt0 = if_resp_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_sram_en", 32'(sram_en), 32'h0);
        check("midrst_if_resp_valid", 32'(if_resp_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_if_resp", 32'(if_resp_cnt - cnt0), 32'h0);
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        #1;
        check("midrst_state_idle", 32'(if_req_ready), 32'h1);
        if_req_valid = 1'b0;
        @(negedge clk);
        issue(mk(0, 0, 2'b10, 0, 32'h0000_0004, 32'h0, 32'h3333_4444, 3));
        drain();

        // Invalid width: no SRAM access, store completes, load returns 0.
        en0 = en_cnt;
        issue(mk(0, 1, 2'b11, 0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 2));
        drain();
        check("w11_store_no_sram_en", 32'(en_cnt - en0), 32'h0);
        issue(mk(0, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'h1234_80EF, 3));
        issue(mk(0, 0, 2'b11, 1, 32'h0000_0100, 32'h0, 32'h0, 3));
        drain();
        check("w11_load_no_sram_en", 32'(en_cnt - en0), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
